clock24_propagator: RTL and testbench
=====================================

Name: clock24_propagator

Overview:
- 24-hour time-of-day counter and protocol bridge to the 12-hour clock subsystem.
- Receives the 12-hour propagate interface (propagate strobe, isPM, hours 1-12, minutes) and converts it into a 24-hour load.
- Drives the extern24 interface (propagate strobe, hours 0-23, minutes 0-59) toward the 12-hour clock whenever the 24-hour time is set locally.
- Contains a hold-off state machine so that a 12-hour set is never echoed back to the 12-hour side.

Parameters:
HOLDOFF_CYCLES, 2, cycles after any load during which in12_propagate is ignored (echo-loop guard); legal range 1-15.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
sec_tick  input  1  one-cycle pulse per elapsed second.
set_load  input  1  one-cycle local set strobe.
set_hours  input  5  local set hours, 0-23.
set_minutes  input  6  local set minutes, 0-59.
in12_propagate  input  1  12-hour side set strobe (one cycle).
in12_isPM  input  1  12-hour side AM/PM flag (1 = PM).
in12_hours  input  5  12-hour side hours, 1-12.
in12_minutes  input  6  12-hour side minutes, 0-59.
hours  output  5  current 24-hour hours, 0-23.
minutes  output  6  current minutes, 0-59.
seconds  output  6  current seconds, 0-59.
out24_propagate  output  1  one-cycle strobe to the 12-hour clock (extern24 propagate).
out24_hours  output  5  hours sent with the strobe; held until the next send.
out24_minutes  output  6  minutes sent with the strobe; held until the next send.
load_err  output  1  one-cycle pulse when a load request is rejected as out of range.

Behaviour:
- Reset, while reset = 0, asynchronous: hours, minutes and seconds = 0; out24_propagate = 0; out24_hours = 0; out24_minutes = 0; load_err = 0; FSM = IDLE; hold-off counter = 0.
- Event priority within a cycle: set_load > in12_propagate > sec_tick. A lower-priority event in the same cycle is discarded and not queued.
- Local set: set_load = 1 with set_hours <= 23 and set_minutes <= 59:
  - the next edge loads hours and minutes, and clears seconds to 0;
  - FSM -> SEND.
  - If either value is out of range: no load, load_err pulses for one cycle, and the FSM is unchanged.
- 12-hour load: in12_propagate = 1, FSM != HOLD, and set_load = 0:
  - Valid input is in12_hours 1-12 and in12_minutes <= 59.
  - Conversion: hours24 = (in12_hours == 12 ? 0 : in12_hours) + (in12_isPM ? 12 : 0). Examples: 12 AM -> 0, 12 PM -> 12, 7 PM -> 19.
  - A valid input loads hours and minutes, clears seconds, and sends FSM -> HOLD with no out24_propagate (no echo).
  - Invalid input: load_err pulse, no state change.
  - in12_propagate while FSM = HOLD is silently dropped, with no load_err.
- Tick: sec_tick increments seconds.
  - 59 -> 0 with carry into minutes; minutes 59 -> 0 with carry into hours; hours 23 -> 0.
  - 23:59:59 + tick -> 00:00:00.
  - Ticking continues in every FSM state.
- FSM states:
  - IDLE: waiting for events.
  - SEND: out24_propagate = 1 for exactly one cycle. out24_hours and out24_minutes are registered from the values loaded on the previous edge, so the strobe appears 1 cycle after the set_load edge. Next state is HOLD.
  - HOLD: the counter runs from HOLDOFF_CYCLES down to 1, one count per cycle; FSM -> IDLE when it expires.
  - A set_load accepted during SEND or HOLD reloads the time and re-enters SEND on the next edge. That new strobe carries the new values.
- out24_hours and out24_minutes change only on entry to SEND. A tick in the same cycle as SEND does not alter the sent values.
- Reset asserted mid-SEND or mid-HOLD aborts immediately; no strobe is produced after reset is released.

Test Plan:
- Reset then 3 sec_tick pulses -> hours = 0, minutes = 0, seconds = 3; out24_propagate stays 0.
- set_load with 23:59, then 60 ticks -> time 00:00:00; exactly one out24_propagate, carrying 23/59, appearing 1 cycle after set_load.
- in12_propagate with PM, 12, 30 -> hours = 12, minutes = 30. Then AM, 12, 05 -> 0:05. Then PM, 7, 45 -> 19:45. No out24_propagate in any of these cases.
- set_load 10:00 and in12_propagate PM, 3, 00 in the same cycle -> time 10:00, one strobe carrying 10/00. A second in12_propagate within HOLDOFF_CYCLES is ignored; one after expiry loads.
- set_hours = 24 -> load_err pulses once, time unchanged. in12_hours = 0 -> load_err, time unchanged. in12_minutes = 60 -> load_err, time unchanged.
- set_load, then reset pulled low the cycle before SEND -> all outputs 0 and no strobe after release. A sec_tick coincident with set_load is discarded (seconds = 0).

Source files
------------

// File: rtl/clock24_propagator.sv
// 24-hour time-of-day counter bridged to a 12-hour clock. Local sets are forwarded
// to the 12-hour side. Sets arriving from the 12-hour side open a hold-off window so they are not echoed back.
module clock24_propagator #(
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       set_load,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic       in12_propagate,
    input  logic       in12_isPM,
    input  logic [4:0] in12_hours,
    input  logic [5:0] in12_minutes,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       out24_propagate,
    output logic [4:0] out24_hours,
    output logic [5:0] out24_minutes,
    output logic       load_err
);

    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned SW = 6;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLDOFF_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hours_q, hours_d;
    logic [MW-1:0]   minutes_q, minutes_d;
    logic [SW-1:0]   seconds_q, seconds_d;
    logic            out24_propagate_q, out24_propagate_d;
    logic [HW-1:0]   out24_hours_q, out24_hours_d;
    logic [MW-1:0]   out24_minutes_q, out24_minutes_d;
    logic            load_err_q, load_err_d;

    logic            set_ok;
    logic            in12_ok;
    logic [HW-1:0]   in12_base;
    logic [HW-1:0]   in12_h24;

    assign set_ok    = (set_hours <= HW'(23)) && (set_minutes <= MW'(59));
    assign in12_ok   = (in12_hours >= HW'(1)) && (in12_hours <= HW'(12)) &&
                       (in12_minutes <= MW'(59));
    // 12 o'clock maps to hour 0 before the PM offset is applied
    assign in12_base = (in12_hours == HW'(12)) ? '0 : in12_hours;
    assign in12_h24  = in12_base + (in12_isPM ? HW'(12) : HW'(0));

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        hours_d           = hours_q;
        minutes_d         = minutes_q;
        seconds_d         = seconds_q;
        out24_propagate_d = 1'b0;
        out24_hours_d     = out24_hours_q;
        out24_minutes_d   = out24_minutes_q;
        load_err_d        = 1'b0;

        // Background FSM progression; a load below may override it
        case (state_q)
            ST_SEND: begin
                out24_propagate_d = 1'b1;
                out24_hours_d     = hours_q;
                out24_minutes_d   = minutes_q;
                state_d           = ST_HOLD;
                cnt_d             = HOLD_INIT;
            end
            ST_HOLD: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase

        // Event priority: local set, then 12-hour set, then second tick
        if (set_load) begin
            if (set_ok) begin
                hours_d   = set_hours;
                minutes_d = set_minutes;
                seconds_d = '0;
                state_d   = ST_SEND;
                cnt_d     = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (in12_propagate && (state_q != ST_HOLD)) begin
            if (in12_ok) begin
                hours_d   = in12_h24;
                minutes_d = in12_minutes;
                seconds_d = '0;
                state_d   = ST_HOLD;
                cnt_d     = HOLD_INIT;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (sec_tick) begin
            if (seconds_q == SW'(59)) begin
                seconds_d = '0;
                if (minutes_q == MW'(59)) begin
                    minutes_d = '0;
                    hours_d   = (hours_q == HW'(23)) ? '0 : hours_q + HW'(1);
                end else begin
                    minutes_d = minutes_q + MW'(1);
                end
            end else begin
                seconds_d = seconds_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            hours_q           <= '0;
            minutes_q         <= '0;
            seconds_q         <= '0;
            out24_propagate_q <= 1'b0;
            out24_hours_q     <= '0;
            out24_minutes_q   <= '0;
            load_err_q        <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            hours_q           <= hours_d;
            minutes_q         <= minutes_d;
            seconds_q         <= seconds_d;
            out24_propagate_q <= out24_propagate_d;
            out24_hours_q     <= out24_hours_d;
            out24_minutes_q   <= out24_minutes_d;
            load_err_q        <= load_err_d;
        end
    end

    assign hours           = hours_q;
    assign minutes         = minutes_q;
    assign seconds         = seconds_q;
    assign out24_propagate = out24_propagate_q;
    assign out24_hours     = out24_hours_q;
    assign out24_minutes   = out24_minutes_q;
    assign load_err        = load_err_q;

endmodule

// File: tb/tb_clock24_propagator.sv
// Self-checking bench for clock24_propagator: directed scenarios plus random traffic
// checked against a seconds-of-day reference model.
module tb_clock24_propagator;

    localparam int HOLDOFF = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick, set_load, in12_propagate, in12_isPM;
    logic [4:0] set_hours, in12_hours;
    logic [5:0] set_minutes, in12_minutes;
    logic [4:0] hours, out24_hours;
    logic [5:0] minutes, seconds, out24_minutes;
    logic       out24_propagate, load_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: time as seconds of day, pending send, hold-off remaining
    int tod;
    bit send_due;
    int hold_left;
    bit exp_strobe, exp_err;
    int exp_oh, exp_om;

    clock24_propagator #(.HOLDOFF_CYCLES(HOLDOFF)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .set_load(set_load),
        .set_hours(set_hours), .set_minutes(set_minutes),
        .in12_propagate(in12_propagate), .in12_isPM(in12_isPM),
        .in12_hours(in12_hours), .in12_minutes(in12_minutes),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .out24_propagate(out24_propagate), .out24_hours(out24_hours),
        .out24_minutes(out24_minutes), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        tod = 0; send_due = 0; hold_left = 0;
        exp_strobe = 0; exp_err = 0; exp_oh = 0; exp_om = 0;
    endtask

    task automatic model_step();
        bit in_hold;
        bit was_send;
        in_hold  = (hold_left > 0);
        was_send = send_due;
        exp_strobe = 0;
        exp_err    = 0;
        if (was_send) begin
            exp_strobe = 1;
            exp_oh = tod / 3600;
            exp_om = (tod / 60) % 60;
        end
        send_due = 0;
        if (was_send) hold_left = HOLDOFF;
        else if (in_hold) hold_left = hold_left - 1;
        if (set_load) begin
            if (set_hours < 24 && set_minutes < 60) begin
                tod = int'(set_hours) * 3600 + int'(set_minutes) * 60;
                send_due = 1;
                hold_left = 0;
            end else exp_err = 1;
        end else if (in12_propagate && !in_hold) begin
            if (in12_hours >= 1 && in12_hours <= 12 && in12_minutes < 60) begin
                tod = ((int'(in12_hours) % 12) + (in12_isPM ? 12 : 0)) * 3600
                      + int'(in12_minutes) * 60;
                hold_left = HOLDOFF;
            end else exp_err = 1;
        end else if (sec_tick) begin
            tod = (tod + 1) % 86400;
        end
    endtask

    task automatic clear_inputs();
        sec_tick = 0; set_load = 0; in12_propagate = 0; in12_isPM = 0;
        set_hours = 0; set_minutes = 0; in12_hours = 0; in12_minutes = 0;
    endtask

    // One clock: advance the model on the inputs being presented, then sample after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({hours, minutes, seconds, out24_propagate, out24_hours, out24_minutes, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got h=%0d m=%0d s=%0d p=%0b oh=%0d om=%0d e=%0b, expected all 0",
                     hours, minutes, seconds, out24_propagate, out24_hours, out24_minutes, load_err);
        end
        reset = 1;
        cycle();
    endtask

    task automatic test_tick();
        int strobes = 0;
        for (int i = 0; i < 3; i++) begin
            sec_tick = 1; cycle();
            sec_tick = 0; cycle();
            if (out24_propagate) strobes++;
        end
        checks++;
        if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd3) begin
            errors++;
            $display("FAIL tick3: got %0d:%0d:%0d, expected 0:0:3", hours, minutes, seconds);
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL tick_no_strobe: got %0d strobes, expected 0", strobes);
        end
    endtask

    task automatic test_set_wrap();
        int strobes = 0;
        int first = -1;
        set_load = 1; set_hours = 5'd23; set_minutes = 6'd59;
        cycle();
        set_load = 0;
        checks++;
        if (out24_propagate !== 1'b0 || hours !== 5'd23 || minutes !== 6'd59 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL set_load: got %0d:%0d:%0d p=%0b, expected 23:59:0 p=0",
                     hours, minutes, seconds, out24_propagate);
        end
        for (int i = 0; i < 60; i++) begin
            sec_tick = 1;
            cycle();
            if (out24_propagate) begin
                strobes++;
                if (first < 0) first = i;
                checks++;
                if (out24_hours !== 5'd23 || out24_minutes !== 6'd59) begin
                    errors++;
                    $display("FAIL send_values: got %0d/%0d, expected 23/59", out24_hours, out24_minutes);
                end
            end
        end
        sec_tick = 0;
        checks++;
        if (strobes != 1 || first != 0) begin
            errors++;
            $display("FAIL send_once: got %0d strobes first at %0d, expected 1 at 0", strobes, first);
        end
        checks++;
        if (hours !== 5'd0 || minutes !== 6'd0 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL midnight_wrap: got %0d:%0d:%0d, expected 0:0:0", hours, minutes, seconds);
        end
        repeat (4) cycle();
    endtask

    task automatic test_in12_conv();
        bit [4:0] hv[3];
        bit [5:0] mv[3];
        bit       pm[3];
        bit [4:0] eh[3];
        int strobes = 0;
        hv = '{5'd12, 5'd12, 5'd7};
        mv = '{6'd30, 6'd5, 6'd45};
        pm = '{1'b1, 1'b0, 1'b1};
        eh = '{5'd12, 5'd0, 5'd19};
        for (int i = 0; i < 3; i++) begin
            in12_propagate = 1; in12_isPM = pm[i]; in12_hours = hv[i]; in12_minutes = mv[i];
            cycle();
            in12_propagate = 0;
            checks++;
            if (hours !== eh[i] || minutes !== mv[i] || seconds !== 6'd0) begin
                errors++;
                $display("FAIL in12_conv%0d: got %0d:%0d:%0d, expected %0d:%0d:0",
                         i, hours, minutes, seconds, eh[i], mv[i]);
            end
            for (int k = 0; k < 4; k++) begin
                if (out24_propagate) strobes++;
                cycle();
            end
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL in12_no_echo: got %0d strobes, expected 0", strobes);
        end
    endtask

    task automatic test_priority_holdoff();
        set_load = 1; set_hours = 5'd10; set_minutes = 6'd0;
        in12_propagate = 1; in12_isPM = 1; in12_hours = 5'd3; in12_minutes = 6'd0;
        sec_tick = 1;
        cycle();
        clear_inputs();
        checks++;
        if (hours !== 5'd10 || minutes !== 6'd0 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL priority: got %0d:%0d:%0d, expected 10:0:0", hours, minutes, seconds);
        end
        cycle();
        checks++;
        if (out24_propagate !== 1'b1 || out24_hours !== 5'd10 || out24_minutes !== 6'd0) begin
            errors++;
            $display("FAIL priority_send: got p=%0b %0d/%0d, expected p=1 10/0",
                     out24_propagate, out24_hours, out24_minutes);
        end
        in12_propagate = 1; in12_isPM = 1; in12_hours = 5'd3; in12_minutes = 6'd0;
        for (int i = 0; i < HOLDOFF; i++) begin
            cycle();
            checks++;
            if (hours !== 5'd10 || load_err !== 1'b0 || out24_propagate !== 1'b0) begin
                errors++;
                $display("FAIL holdoff_drop%0d: got h=%0d err=%0b p=%0b, expected h=10 err=0 p=0",
                         i, hours, load_err, out24_propagate);
            end
        end
        cycle();
        clear_inputs();
        checks++;
        if (hours !== 5'd15 || minutes !== 6'd0) begin
            errors++;
            $display("FAIL holdoff_expiry: got %0d:%0d, expected 15:0", hours, minutes);
        end
        repeat (4) cycle();
    endtask

    task automatic test_load_err();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            if (i == 0) begin
                set_load = 1; set_hours = 5'd24; set_minutes = 6'd10;
            end else begin
                in12_propagate = 1; in12_isPM = 1;
                in12_hours   = (i == 1) ? 5'd0 : 5'd4;
                in12_minutes = (i == 1) ? 6'd10 : 6'd60;
            end
            cycle();
            clear_inputs();
            checks++;
            if (load_err !== 1'b1 || hours !== 5'd15 || minutes !== 6'd0 || seconds !== 6'd0) begin
                errors++;
                $display("FAIL load_err%0d: got err=%0b %0d:%0d:%0d, expected err=1 15:0:0",
                         i, load_err, hours, minutes, seconds);
            end
            cycle();
            checks++;
            if (load_err !== 1'b0 || out24_propagate !== 1'b0) begin
                errors++;
                $display("FAIL load_err_pulse%0d: got err=%0b p=%0b, expected 0 0", i, load_err, out24_propagate);
            end
        end
    endtask

    task automatic test_reset_abort();
        int strobes = 0;
        set_load = 1; set_hours = 5'd8; set_minutes = 6'd30; sec_tick = 1;
        cycle();
        clear_inputs();
        checks++;
        if (hours !== 5'd8 || minutes !== 6'd30 || seconds !== 6'd0) begin
            errors++;
            $display("FAIL tick_discard: got %0d:%0d:%0d, expected 8:30:0", hours, minutes, seconds);
        end
        #2;
        reset = 0;
        model_reset();
        #1;
        checks++;
        if ({hours, minutes, seconds, out24_propagate, out24_hours, out24_minutes, load_err} !== '0) begin
            errors++;
            $display("FAIL reset_abort: got h=%0d m=%0d s=%0d p=%0b oh=%0d om=%0d, expected all 0",
                     hours, minutes, seconds, out24_propagate, out24_hours, out24_minutes);
        end
        @(posedge clk);
        #1;
        reset = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (out24_propagate) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL reset_no_strobe: got %0d strobes, expected 0", strobes);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            sec_tick       = ($urandom_range(0, 1) == 1);
            set_load       = ($urandom_range(0, 15) == 0);
            set_hours      = 5'($urandom_range(0, 25));
            set_minutes    = 6'($urandom_range(0, 61));
            in12_propagate = ($urandom_range(0, 7) == 0);
            in12_isPM      = 1'($urandom_range(0, 1));
            in12_hours     = 5'($urandom_range(0, 13));
            in12_minutes   = 6'($urandom_range(0, 61));
            cycle();
            checks++;
            if (hours !== 5'(tod / 3600) || minutes !== 6'((tod / 60) % 60) || seconds !== 6'(tod % 60)) begin
                errors++;
                $display("FAIL rand_time@%0d: got %0d:%0d:%0d, expected %0d:%0d:%0d", n,
                         hours, minutes, seconds, tod / 3600, (tod / 60) % 60, tod % 60);
            end
            checks++;
            if (out24_propagate !== exp_strobe || load_err !== exp_err) begin
                errors++;
                $display("FAIL rand_pulses@%0d: got p=%0b err=%0b, expected p=%0b err=%0b", n,
                         out24_propagate, load_err, exp_strobe, exp_err);
            end
            checks++;
            if (out24_hours !== 5'(exp_oh) || out24_minutes !== 6'(exp_om)) begin
                errors++;
                $display("FAIL rand_sent@%0d: got %0d/%0d, expected %0d/%0d", n,
                         out24_hours, out24_minutes, exp_oh, exp_om);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_tick();
        test_set_wrap();
        test_in12_conv();
        test_priority_holdoff();
        test_load_err();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
